add_seq: RTL and testbench
==========================

ADD_SEQ -- requirements
Module: add_seq

Interface
REQ-001 Parameter N, default 176: lanes per tile, 8-bit each.
REQ-002 Parameter AW, default 10: scratchpad address width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  high only in IDLE.
REQ-007 cmd_addr_a, cmd_addr_b, cmd_addr_c  in  AW each  base tile addresses of operand A, operand B and result C.
REQ-008 cmd_len  in  8  tile count; 0 is a legal no-op.
REQ-009 cmd_s_a, cmd_s_b  in  16 each; cmd_z_tot  in  8 signed  scaling and zero terms for the add datapath.
REQ-010 rd_en  out  1; rd_addr_a, rd_addr_b  out  AW each  dual-port scratchpad read request.
REQ-011 rd_data_a, rd_data_b  in  N*8 each  read data, valid exactly 1 cycle after rd_en.
REQ-012 dp_a, dp_b  out  N*8 each; dp_s_a, dp_s_b  out  16 each; dp_z_tot  out  8  add datapath operands and config.
REQ-013 dp_c  in  N*8  combinational datapath result.
REQ-014 wr_en  out  1; wr_addr  out  AW; wr_data  out  N*8  scratchpad write port.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 done  out  1  one-cycle pulse at command completion.

Function
REQ-017 The FSM SHALL use states IDLE, RD, CAP, WR, DONE.
REQ-018 Accept: cmd_valid and cmd_ready both high at a clock edge; latch all cmd_* fields and clear tile index idx to 0.
REQ-019 On accept, the FSM SHALL go to DONE if cmd_len==0; otherwise it SHALL go to RD.
REQ-020 RD: rd_en=1, rd_addr_a=base_a+idx, rd_addr_b=base_b+idx; the next state is CAP.
REQ-021 CAP: register rd_data_a/rd_data_b into dp_a/dp_b; the next state is WR.
REQ-022 WR: wr_en=1, wr_addr=base_c+idx, wr_data=dp_c.
REQ-023 Exit from WR: if idx==len-1 go to DONE, otherwise increment idx and go to RD.
REQ-024 DONE: done=1 for one cycle; the next state is IDLE.
REQ-025 Tile throughput SHALL be 3 cycles per tile.
REQ-026 Command latency from the accept edge to the done cycle SHALL be 3*len+1 cycles.
REQ-027 Address sums SHALL wrap modulo 2^AW with no error indication.
REQ-028 dp_s_a, dp_s_b and dp_z_tot SHALL hold the latched values from accept until the next accept.
REQ-029 cmd_valid while cmd_ready is low SHALL be ignored and SHALL NOT be queued.
REQ-030 rd_en and wr_en SHALL be 0 in IDLE, CAP and DONE; rd_en and wr_en SHALL never be high in the same cycle.
REQ-031 A new command presented in the cycle after done SHALL be accepted that cycle.

Reset
REQ-032 On rst_n low: state=IDLE, idx=0, and all latched fields and dp_* outputs cleared to 0.
REQ-033 On rst_n low: rd_en, wr_en, done and busy = 0; cmd_ready = 1 from the first edge after release.
REQ-034 Reset mid-command SHALL abort the command immediately: no further rd_en or wr_en, and no done pulse.

Configuration
REQ-035 Macro ADD_SEQ_PERF_EN defined: add output perf_cycles (32 bits).
REQ-036 perf_cycles SHALL be cleared to 0 on accept and increment every cycle while busy, saturating at 0xFFFFFFFF.
REQ-037 perf_cycles SHALL hold its value in IDLE and reset to 0.
REQ-038 Macro ADD_SEQ_PERF_EN undefined: port and counter absent; all other behaviour identical.

Verification
REQ-039 len=1, a=0x010, b=0x020, c=0x030 -> rd at 0x010/0x020, wr at 0x030 three cycles after accept, done on cycle 4.
REQ-040 len=4, a=0x3FE (AW=10) -> rd_addr_a sequence 0x3FE, 0x3FF, 0x000, 0x001; done 13 cycles after accept.
REQ-041 len=0 -> no rd_en or wr_en, done 1 cycle after accept, cmd_ready back high the following cycle.
REQ-042 cmd_valid held high during a len=2 command, then a second command back-to-back -> second accepted in the cycle after done, with its own addresses.
REQ-043 rst_n pulsed low during WR of tile 1 of len=3 -> wr_en falls asynchronously, no done, busy=0, next command runs normally.
REQ-044 With ADD_SEQ_PERF_EN defined, len=5 -> perf_cycles reads 16 in IDLE after done.

Source files
------------

// File: rtl/add_seq.sv
`default_nettype none
// ============================================================================
//  Module   : add_seq
//  Purpose  : Tile sequencer for the elementwise add datapath. It accepts one
//             command, then for each tile reads operands A and B from a
//             dual-port scratchpad, registers them into the add datapath, and
//             writes the datapath result to C. Each tile takes three cycles
//             (RD, CAP, WR). A DONE pulse closes the command.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    N  : lanes per tile, 8 bits per lane
//    AW : scratchpad address width
//  Ports
//    clk, rst_n             clock, asynchronous active-low reset
//    cmd_valid/cmd_ready    command handshake (ready only while idle)
//    cmd_addr_a/b/c         base tile addresses of A, B and C
//    cmd_len                tile count (0 = no-op)
//    cmd_s_a/s_b/z_tot      datapath scaling and zero terms
//    rd_en, rd_addr_a/b     scratchpad read request
//    rd_data_a/b            read data, valid one cycle after rd_en
//    dp_a/b, dp_s_a/b,
//    dp_z_tot               datapath operands and configuration
//    dp_c                   combinational datapath result
//    wr_en, wr_addr,
//    wr_data                scratchpad write port
//    busy, done             status; done is a one-cycle pulse
//    perf_cycles            busy-cycle counter (only with ADD_SEQ_PERF_EN)
//  Build option
//    ADD_SEQ_PERF_EN        define to add the perf_cycles counter and port
// ============================================================================
module add_seq #(
    parameter int N  = 176,
    parameter int AW = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [AW-1:0]        cmd_addr_a,
    input  logic [AW-1:0]        cmd_addr_b,
    input  logic [AW-1:0]        cmd_addr_c,
    input  logic [7:0]           cmd_len,
    input  logic [15:0]          cmd_s_a,
    input  logic [15:0]          cmd_s_b,
    input  logic signed [7:0]    cmd_z_tot,
    output logic                 rd_en,
    output logic [AW-1:0]        rd_addr_a,
    output logic [AW-1:0]        rd_addr_b,
    input  logic [N*8-1:0]       rd_data_a,
    input  logic [N*8-1:0]       rd_data_b,
    output logic [N*8-1:0]       dp_a,
    output logic [N*8-1:0]       dp_b,
    output logic [15:0]          dp_s_a,
    output logic [15:0]          dp_s_b,
    output logic signed [7:0]    dp_z_tot,
    input  logic [N*8-1:0]       dp_c,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [N*8-1:0]       wr_data,
    output logic                 busy,
    output logic                 done
`ifdef ADD_SEQ_PERF_EN
    ,
    output logic [31:0]          perf_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e                state_q;
    logic [7:0]            idx_q;
    logic [7:0]            len_q;
    logic [AW-1:0]         base_a_q;
    logic [AW-1:0]         base_b_q;
    logic [AW-1:0]         base_c_q;
    logic [15:0]           s_a_q;
    logic [15:0]           s_b_q;
    logic signed [7:0]     z_tot_q;
    logic [N*8-1:0]        dp_a_q;
    logic [N*8-1:0]        dp_b_q;
    logic                  rd_en_q;
    logic [AW-1:0]         rd_addr_a_q;
    logic [AW-1:0]         rd_addr_b_q;
    logic                  wr_en_q;
    logic [AW-1:0]         wr_addr_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  cmd_ready_q;

    logic                  w_accept;
    logic [7:0]            idx_d;
    logic [AW-1:0]         w_idx_aw;
    logic [AW-1:0]         w_idx_d_aw;

    assign w_accept   = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;
    assign idx_d      = idx_q + 8'd1;
    // Address sums are taken at AW bits so they wrap around the scratchpad.
    assign w_idx_aw   = AW'(idx_q);
    assign w_idx_d_aw = AW'(idx_d);

    // All outputs are registered alongside the state, so each one is decided
    // on the edge that enters the state in which it must be visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            base_a_q    <= '0;
            base_b_q    <= '0;
            base_c_q    <= '0;
            s_a_q       <= '0;
            s_b_q       <= '0;
            z_tot_q     <= '0;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (w_accept) begin
                        len_q       <= cmd_len;
                        base_a_q    <= cmd_addr_a;
                        base_b_q    <= cmd_addr_b;
                        base_c_q    <= cmd_addr_c;
                        s_a_q       <= cmd_s_a;
                        s_b_q       <= cmd_s_b;
                        z_tot_q     <= cmd_z_tot;
                        idx_q       <= '0;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (cmd_len == 8'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= S_RD;
                            rd_en_q     <= 1'b1;
                            rd_addr_a_q <= cmd_addr_a;
                            rd_addr_b_q <= cmd_addr_b;
                        end
                    end
                end
                S_RD: begin
                    state_q <= S_CAP;
                end
                S_CAP: begin
                    // Read data arrives in this cycle, one after rd_en.
                    dp_a_q    <= rd_data_a;
                    dp_b_q    <= rd_data_b;
                    state_q   <= S_WR;
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= base_c_q + w_idx_aw;
                end
                S_WR: begin
                    if (idx_q == len_q - 8'd1) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q       <= idx_d;
                        state_q     <= S_RD;
                        rd_en_q     <= 1'b1;
                        rd_addr_a_q <= base_a_q + w_idx_d_aw;
                        rd_addr_b_q <= base_b_q + w_idx_d_aw;
                    end
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rd_en     = rd_en_q;
    assign rd_addr_a = rd_addr_a_q;
    assign rd_addr_b = rd_addr_b_q;
    assign dp_a      = dp_a_q;
    assign dp_b      = dp_b_q;
    assign dp_s_a    = s_a_q;
    assign dp_s_b    = s_b_q;
    assign dp_z_tot  = z_tot_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = dp_c;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef ADD_SEQ_PERF_EN
    logic [31:0] perf_q;

    // Counts busy cycles of the current command; holds while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (w_accept) begin
            perf_q <= '0;
        end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_add_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add_seq
//  Purpose  : Self-checking bench for add_seq. A scratchpad and a lane-wise
//             datapath are modelled here; every command is checked cycle by
//             cycle against the expected RD/CAP/WR timing, addresses and
//             write data derived from the scratchpad contents.
//  Revision : 1.0  initial release
// ============================================================================
module tb_add_seq;

    localparam int N  = 16;
    localparam int AW = 10;
    localparam int DW = N * 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [AW-1:0]        cmd_addr_a, cmd_addr_b, cmd_addr_c;
    logic [7:0]           cmd_len;
    logic [15:0]          cmd_s_a, cmd_s_b;
    logic [7:0]           cmd_z_tot;
    logic                 rd_en;
    logic [AW-1:0]        rd_addr_a, rd_addr_b;
    logic [DW-1:0]        rd_data_a, rd_data_b;
    logic [DW-1:0]        dp_a, dp_b;
    logic [15:0]          dp_s_a, dp_s_b;
    logic [7:0]           dp_z_tot;
    logic [DW-1:0]        dp_c;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [DW-1:0]        wr_data;
    logic                 busy;
    logic                 done;
`ifdef ADD_SEQ_PERF_EN
    logic [31:0]          perf_cycles;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    add_seq #(.N(N), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr_a (cmd_addr_a),
        .cmd_addr_b (cmd_addr_b),
        .cmd_addr_c (cmd_addr_c),
        .cmd_len    (cmd_len),
        .cmd_s_a    (cmd_s_a),
        .cmd_s_b    (cmd_s_b),
        .cmd_z_tot  (cmd_z_tot),
        .rd_en      (rd_en),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .dp_a       (dp_a),
        .dp_b       (dp_b),
        .dp_s_a     (dp_s_a),
        .dp_s_b     (dp_s_b),
        .dp_z_tot   (dp_z_tot),
        .dp_c       (dp_c),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done)
`ifdef ADD_SEQ_PERF_EN
        ,
        .perf_cycles(perf_cycles)
`endif
    );

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Datapath stand-in: any lane-wise function of every operand will do.
    function automatic logic [DW-1:0] dp_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [15:0] sa, input logic [15:0] sb,
                                            input logic [7:0] z);
        logic [DW-1:0] r;
        for (int i = 0; i < N; i++)
            r[i*8 +: 8] = a[i*8 +: 8] + b[i*8 +: 8] + z + (sa[7:0] ^ sb[15:8]) + 8'(i);
        return r;
    endfunction

    assign dp_c = dp_fn(dp_a, dp_b, dp_s_a, dp_s_b, dp_z_tot);

    // Scratchpad: data valid one cycle after rd_en, garbage otherwise.
    always @(posedge clk) begin
        rd_data_a <= rd_en ? mem[rd_addr_a] : rnd_word();
        rd_data_b <= rd_en ? mem[rd_addr_b] : rnd_word();
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic scramble_cmd();
        cmd_addr_a = AW'($urandom);
        cmd_addr_b = AW'($urandom);
        cmd_addr_c = AW'($urandom);
        cmd_len    = 8'($urandom);
        cmd_s_a    = 16'($urandom);
        cmd_s_b    = 16'($urandom);
        cmd_z_tot  = 8'($urandom);
    endtask

    // Offers a command, waits for acceptance, then checks every cycle up to
    // and including the done cycle. abort_k >= 0 asserts reset just after the
    // check of cycle k and returns.
    task automatic run_cmd(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c,
                           input logic [7:0] len, input logic [15:0] sa, input logic [15:0] sb,
                           input logic [7:0] z, input bit hold, input int abort_k,
                           output int acc);
        int waited;
        waited     = 0;
        cmd_addr_a = a;
        cmd_addr_b = b;
        cmd_addr_c = c;
        cmd_len    = len;
        cmd_s_a    = sa;
        cmd_s_b    = sb;
        cmd_z_tot  = z;
        cmd_valid  = 1'b1;
        while (cmd_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (cmd_ready !== 1'b1) begin
            check("accept_timeout", {{(DW-1){1'b0}}, cmd_ready}, 1);
            cmd_valid = 1'b0;
            acc = -1;
            return;
        end
        check("idle_busy", busy, 0);
        acc = cyc + 1;
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
        scramble_cmd();
        for (int k = 0; k <= 3 * int'(len); k++) begin
            int t, ph;
            bit last;
            logic [AW-1:0] ea, eb, ec;
            @(negedge clk);
            t    = k / 3;
            ph   = k % 3;
            last = (k == 3 * int'(len));
            ea   = a + AW'(t);
            eb   = b + AW'(t);
            ec   = c + AW'(t);
            check("busy", busy, 1);
            check("cmd_ready_busy", cmd_ready, 0);
            check("done", done, last);
            check("rd_en", rd_en, !last && ph == 0);
            check("wr_en", wr_en, !last && ph == 2);
            check("dp_s_a", dp_s_a, sa);
            check("dp_s_b", dp_s_b, sb);
            check("dp_z_tot", dp_z_tot, z);
            if (!last && ph == 0) begin
                check("rd_addr_a", rd_addr_a, ea);
                check("rd_addr_b", rd_addr_b, eb);
            end
            if (!last && ph == 2) begin
                check("dp_a", dp_a, mem[ea]);
                check("wr_addr", wr_addr, ec);
                check("wr_data", wr_data, dp_fn(mem[ea], mem[eb], sa, sb, z));
            end
`ifdef ADD_SEQ_PERF_EN
            check("perf_run", perf_cycles, k);
`endif
            if (k == abort_k) begin
                #1 rst_n = 1'b0;
                #1;
                check("abort_wr_en", wr_en, 0);
                check("abort_rd_en", rd_en, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                return;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc1;
        logic [AW-1:0] ra, rb, rc;
        for (int i = 0; i < (1 << AW); i++) mem[i] = rnd_word();
        cmd_valid = 1'b0;
        scramble_cmd();

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd_en", rd_en, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_dp_a", dp_a, 0);
        check("rst_dp_s_a", dp_s_a, 0);
        check("rst_dp_z_tot", dp_z_tot, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", cmd_ready, 1);

        // Single tile at fixed addresses
        run_cmd(10'h010, 10'h020, 10'h030, 8'd1, 16'h1234, 16'h5678, 8'hF3, 1'b0, -1, acc);

        // Address wrap on A
        run_cmd(10'h3FE, AW'($urandom), AW'($urandom), 8'd4, 16'($urandom), 16'($urandom),
                8'($urandom), 1'b0, -1, acc);

        // Zero-length command
        run_cmd(AW'($urandom), AW'($urandom), AW'($urandom), 8'd0, 16'($urandom), 16'($urandom),
                8'($urandom), 1'b0, -1, acc);
        @(negedge clk);
        check("len0_ready_after", cmd_ready, 1);
        check("len0_busy_after", busy, 0);

        // valid held through a len=2 command, second command back-to-back
        run_cmd(AW'($urandom), AW'($urandom), AW'($urandom), 8'd2, 16'($urandom), 16'($urandom),
                8'($urandom), 1'b1, -1, acc1);
        run_cmd(AW'($urandom), AW'($urandom), AW'($urandom), 8'd3, 16'($urandom), 16'($urandom),
                8'($urandom), 1'b0, -1, acc);
        check("b2b_accept_edge", 32'(acc), 32'(acc1 + 3 * 2 + 2));

        // Reset during WR of tile 1 of a len=3 command
        repeat (2) @(negedge clk);
        run_cmd(AW'($urandom), AW'($urandom), AW'($urandom), 8'd3, 16'($urandom), 16'($urandom),
                8'($urandom), 1'b0, 5, acc);
        cmd_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("inrst_rd_en", rd_en, 0);
            check("inrst_wr_en", wr_en, 0);
            check("inrst_done", done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_ready", cmd_ready, 1);
        check("postrst_busy", busy, 0);
        check("postrst_dp_s_a", dp_s_a, 0);
        run_cmd(AW'($urandom), AW'($urandom), AW'($urandom), 8'd2, 16'($urandom), 16'($urandom),
                8'($urandom), 1'b0, -1, acc);

        // len=5, performance counter holds in idle
        run_cmd(AW'($urandom), AW'($urandom), AW'($urandom), 8'd5, 16'($urandom), 16'($urandom),
                8'($urandom), 1'b0, -1, acc);
        @(negedge clk);
        check("idle_after_len5", busy, 0);
`ifdef ADD_SEQ_PERF_EN
        check("perf_len5", perf_cycles, 16);
        repeat (3) @(negedge clk);
        check("perf_hold", perf_cycles, 16);
`endif

        // Randomized commands with random idle gaps
        for (int i = 0; i < 15; i++) begin
            ra = AW'($urandom);
            rb = AW'($urandom);
            rc = AW'($urandom);
            run_cmd(ra, rb, rc, 8'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                    8'($urandom), 1'($urandom_range(0, 1)), -1, acc);
            cmd_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
